// File: rtl/sparse_chunk_encoder_if.sv
// Handshake bundle for sparse_chunk_encoder.
// It carries the dense element input and the encoded chunk output.
interface sparse_chunk_encoder_if #(
  parameter int unsigned CHUNK_SIZE = 128,
  parameter int unsigned Q          = 8
);
  localparam int unsigned CW = $clog2(CHUNK_SIZE) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [Q-1:0]          in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHUNK_SIZE-1:0] out_sparsemap;
  logic [Q-1:0]          out_data [CHUNK_SIZE];
  logic [CW-1:0]         out_nnz;
  logic [CW-1:0]         out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sparsemap, out_data, out_nnz, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sparsemap, out_data, out_nnz, out_len
  );
endinterface

// File: rtl/sparse_chunk_encoder.sv
// Packs a dense element stream into chunks: a sparsemap plus the nonzero values in position order.
// Define SPARSE_PRUNE_EN to treat values at or below PRUNE_THRESH as zero.
module sparse_chunk_encoder #(
  parameter int unsigned CHUNK_SIZE   = 128,
  parameter int unsigned Q            = 8,
  parameter int unsigned PRUNE_THRESH = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sparse_chunk_encoder_if.slave   bus
);
  localparam int unsigned PW = $clog2(CHUNK_SIZE);
  localparam int unsigned CW = PW + 1;
  localparam logic [Q-1:0] THRESH = Q'(PRUNE_THRESH);

  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e                state_q;
  logic [PW-1:0]         pos_q;
  logic [CW-1:0]         nnz_q;
  logic [CW-1:0]         len_q;
  logic [CHUNK_SIZE-1:0] map_q;
  logic [Q-1:0]          data_q [CHUNK_SIZE];
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic nz_c;
  logic accept_c;
  logic close_c;

`ifdef SPARSE_PRUNE_EN
  assign nz_c = bus.in_data > THRESH;
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign nz_c = bus.in_data != '0;
`endif

  assign accept_c = bus.in_valid && in_ready_q;
  assign close_c  = accept_c && ((pos_q == PW'(CHUNK_SIZE - 1)) || bus.in_last);

  // Chunk builder: fill until full or in_last, then hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      pos_q       <= '0;
      nnz_q       <= '0;
      len_q       <= '0;
      map_q       <= '0;
      data_q      <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept_c) begin
            map_q[pos_q] <= nz_c;
            pos_q        <= pos_q + PW'(1);
            if (nz_c) begin
              data_q[nnz_q[PW-1:0]] <= bus.in_data;
              nnz_q                 <= nnz_q + CW'(1);
            end
            if (close_c) begin
              state_q     <= S_HOLD;
              len_q       <= CW'(pos_q) + CW'(1);
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= S_FILL;
            pos_q       <= '0;
            nnz_q       <= '0;
            map_q       <= '0;
            data_q      <= '{default: '0};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_sparsemap = map_q;
  assign bus.out_data      = data_q;
  assign bus.out_nnz       = nnz_q;
  assign bus.out_len       = len_q;
endmodule

// File: tb/tb_sparse_chunk_encoder.sv
// Bench for sparse_chunk_encoder: directed chunks with literal expectations plus random traffic
// checked every cycle against a queue-based chunk model.
module tb_sparse_chunk_encoder;
  localparam int unsigned CS = 8;
  localparam int unsigned QW = 8;
`ifdef SPARSE_PRUNE_EN
  localparam int unsigned THR = 4;
`else
  localparam int unsigned THR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_chunk_encoder_if #(.CHUNK_SIZE(CS), .Q(QW)) bus ();

  sparse_chunk_encoder #(.CHUNK_SIZE(CS), .Q(QW), .PRUNE_THRESH(THR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_nz(input logic [7:0] v);
`ifdef SPARSE_PRUNE_EN
    return int'(v) > int'(THR);
`else
    return v != 8'd0;
`endif
  endfunction

  // Reference model: list of accepted elements, expected chunk derived when it closes.
  logic [7:0] m_elems [$];
  int         m_vals  [$];
  logic [7:0] m_map;
  int         m_len;
  bit         m_hold;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_elems.delete();
      m_vals.delete();
      m_hold = 1'b0;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
    chk("in_ready", 32'(bus.in_ready), 32'(!m_hold));
    if (m_hold) begin
      chk("out_sparsemap", 32'(bus.out_sparsemap), 32'(m_map));
      chk("out_nnz", 32'(bus.out_nnz), 32'(m_vals.size()));
      chk("out_len", 32'(bus.out_len), 32'(m_len));
      for (int k = 0; k < int'(CS); k++)
        chk($sformatf("out_data[%0d]", k), 32'(bus.out_data[k]),
            (k < m_vals.size()) ? 32'(m_vals[k]) : 32'd0);
    end
    if (rst_n) begin
      if (!m_hold) begin
        if (bus.in_valid) begin
          m_elems.push_back(bus.in_data);
          if (m_elems.size() == int'(CS) || bus.in_last) begin
            m_len = m_elems.size();
            m_map = 8'd0;
            m_vals.delete();
            for (int p = 0; p < m_elems.size(); p++)
              if (is_nz(m_elems[p])) begin
                m_map[p] = 1'b1;
                m_vals.push_back(int'(m_elems[p]));
              end
            m_hold = 1'b1;
          end
        end
      end else if (bus.out_ready) begin
        m_hold = 1'b0;
        m_elems.delete();
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send8(input logic [7:0] v [8]);
    for (int i = 0; i < 8; i++) send(v[i], 1'b0);
  endtask

  // Literal expectation of the held chunk at the next negedge; returns at posedge+1.
  task automatic expect_chunk(input string tag, input logic [7:0] map, input int nnz,
                              input int len, input logic [7:0] vals [8]);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, ".map"}, 32'(bus.out_sparsemap), 32'(map));
    chk({tag, ".nnz"}, 32'(bus.out_nnz), 32'(nnz));
    chk({tag, ".len"}, 32'(bus.out_len), 32'(len));
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s.data[%0d]", tag, k), 32'(bus.out_data[k]), 32'(vals[k]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    @(negedge clk);
    chk("rst.map", 32'(bus.out_sparsemap), 32'd0);
    chk("rst.nnz", 32'(bus.out_nnz), 32'd0);
    chk("rst.len", 32'(bus.out_len), 32'd0);
    chk("rst.data0", 32'(bus.out_data[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full chunk, out_valid must last exactly one cycle.
    send8('{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd9, 8'd0});
    expect_chunk("full", 8'b0101_0010, 3, 8, '{8'd5, 8'd7, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    @(negedge clk);
    chk("full.one_cycle", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Early close.
    send(8'd3, 1'b0); send(8'd0, 1'b0); send(8'd4, 1'b1);
`ifdef SPARSE_PRUNE_EN
    expect_chunk("early", 8'b0000_0000, 0, 3, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
`else
    expect_chunk("early", 8'b0000_0101, 2, 3, '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
`endif

    // Backpressure with a dense full chunk and in_valid held high.
    bus.out_ready = 1'b0;
    send8('{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17});
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd20;
    for (int i = 0; i < 10; i++)
      expect_chunk("bp", 8'hFF, 8, 8, '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17});
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.pulse_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp.resume_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(8'd0, 1'b0);
    expect_chunk("bp_next", 8'h01, 1, 8, '{8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});

    // All-zero chunk still emitted.
    send8('{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    expect_chunk("zero", 8'h00, 0, 8, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});

    // Reset mid-chunk discards partial state.
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.nnz", 32'(bus.out_nnz), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send8('{8'd0, 8'd6, 8'd0, 8'd6, 8'd0, 8'd6, 8'd0, 8'd6});
    expect_chunk("clean", 8'hAA, 4, 8, '{8'd6, 8'd6, 8'd6, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0});

    // Threshold pattern.
    send8('{8'd4, 8'd5, 8'd1, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0});
`ifdef SPARSE_PRUNE_EN
    expect_chunk("prune", 8'b0000_1010, 2, 8, '{8'd5, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
`else
    expect_chunk("prune", 8'b0000_1111, 4, 8, '{8'd4, 8'd5, 8'd1, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0});
`endif

    // Random traffic, checked by the model every cycle.
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_data   = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom);
      bus.in_last   = $urandom_range(0, 9) == 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sparse_chunk_encoder.md
Name: sparse_chunk_encoder

Overview:
- Upstream stage of the sparse compute unit.
- Accepts a dense stream of Q-bit activations or weights, one element per cycle, over a valid/ready handshake.
- Builds one CHUNK_SIZE chunk at a time: a sparsemap bit per position, plus a packed array of nonzero values in ascending position order.
- The data index of the element at position p equals the number of set sparsemap bits below p, which is the prefix-sum indexing the compute unit expects. The chunk is presented on a valid/ready output port.

Parameters:
- CHUNK_SIZE, 128, positions per chunk; power of two, at least 4.
- Q, 8, element width in bits; values treated as unsigned.
- PRUNE_THRESH, 0, magnitude threshold; used only when SPARSE_PRUNE_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  encoder can accept an element.
- in_data  in  Q  dense element.
- in_last  in  1  element is the final one of the chunk (early close).
- out_valid  out  1  chunk available.
- out_ready  in  1  consumer takes the chunk.
- out_sparsemap  out  CHUNK_SIZE  bit p = 1 iff position p is nonzero.
- out_data  out  Q x CHUNK_SIZE (unpacked array)  packed nonzero values; slot k holds the k-th nonzero.
- out_nnz  out  clog2(CHUNK_SIZE)+1  number of nonzero elements.
- out_len  out  clog2(CHUNK_SIZE)+1  number of positions accepted, 1..CHUNK_SIZE.

Behaviour:
- Reset values: state FILL; pos = 0; nnz = 0; sparsemap, data buffer, out_nnz and out_len all zero; out_valid = 0; in_ready = 1 after reset.
- Reset asserted mid-chunk discards partial contents with no output.
- FSM has two states, FILL and HOLD.
- FILL:
  - in_ready = 1, out_valid = 0.
  - Accept fires when in_valid && in_ready.
  - On accept: sparsemap[pos] <= nz, where nz = (in_data != 0).
  - If nz: data[nnz] <= in_data and nnz <= nnz + 1.
  - pos <= pos + 1.
  - Close condition: accept && (pos == CHUNK_SIZE-1 || in_last).
  - On close: move to HOLD and set len <= pos + 1.
  - The nnz, sparsemap and data updates from the closing element land in the same edge.
  - in_valid without accept and in_last without in_valid have no effect.
- HOLD:
  - out_valid = 1, in_ready = 0.
  - All out_* outputs are registers and stay stable until out_valid && out_ready.
  - On that handshake: next state FILL, with pos, nnz, sparsemap and all data slots cleared to 0 at the same edge.
  - out_valid = 0 and in_ready = 1 in the following cycle.
- Latency and throughput:
  - out_valid rises the cycle after the closing element is accepted.
  - Minimum period is CHUNK_SIZE+1 cycles per full chunk when out_ready is tied high.
- Unfilled positions (early close) have sparsemap bit 0.
- Unused data slots (index >= nnz) read 0.
- An all-zero chunk is still emitted, with out_sparsemap = 0 and out_nnz = 0.
- out_nnz never exceeds out_len; both reach CHUNK_SIZE only for a fully dense, full chunk.
- in_ready is purely state-decoded; there is no combinational path from in_valid or out_ready to in_ready or out_valid.

Optional Feature:
- Macro SPARSE_PRUNE_EN.
- When defined: nz = (in_data > PRUNE_THRESH). Elements at or below the threshold are marked 0 in the sparsemap and not stored; stored values are unmodified.
- When undefined: nz = (in_data != 0) and PRUNE_THRESH is ignored.

Test Plan (bench uses CHUNK_SIZE=8, Q=8):
- Full chunk with out_ready=1:
  - Stimulus: in_data 0,5,0,0,7,0,9,0.
  - Expect: out_sparsemap=8'b0101_0010, out_data[0..2]=5,7,9, slots 3..7 = 0, out_nnz=3, out_len=8.
  - out_valid for exactly 1 cycle, asserted the cycle after the 8th accept.
- Early close: in_data 3,0,4 with in_last on the third element -> out_sparsemap=8'b0000_0101, out_data[0..1]=3,4, out_nnz=2, out_len=3.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 throughout.
  - Expect: in_ready=0 and outputs stable; on the out_ready pulse, the next chunk's first element is accepted one cycle later.
- All-zero chunk: 8 zeros -> out_valid=1, out_sparsemap=0, out_nnz=0, out_len=8.
- Reset mid-chunk: assert rst_n=0 after 4 accepts -> out_valid=0, in_ready=1; next 8 elements form a clean chunk with no stale bits.
- SPARSE_PRUNE_EN with PRUNE_THRESH=4:
  - Stimulus: in_data 4,5,1,200,0,0,0,0.
  - Expect: out_sparsemap=8'b0000_1010, out_data[0..1]=5,200, out_nnz=2.
